// File: rtl/cla_pkg.sv
// Shared constants and configuration helpers for the pipelined CLA adder.
package cla_pkg;
    localparam int CLA_WIDTH = 28;
    localparam int CLA_GROUP = 4;
    localparam int CLA_STAGES = 3;

    function automatic int cla_ngroup(input int width, input int group);
        return width / group;
    endfunction

    function automatic bit cla_cfg_ok(input int width, input int group);
        return (group > 0) && (width > 0) && ((width % group) == 0);
    endfunction
endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead slice: group propagate/generate from bit p/g, and
// the in-group carries (carry into each bit) from the group carry-in.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             c_in,
    output logic             gp,
    output logic             gg,
    output logic [GROUP-1:0] c
);
    always_comb begin
        logic cr;
        gp = &p;
        gg = 1'b0;
        cr = c_in;
        c  = '0;
        for (int i = 0; i < GROUP; i++) begin
            c[i] = cr;
            cr   = g[i] | (p[i] & cr);
            gg   = g[i] | (p[i] & gg);
        end
    end
endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined two-level carry-lookahead adder with valid/ready flow.
// Optional group P/G outputs are enabled by defining CLA_PIPE_PG_OUT_EN.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLA_PIPE_PG_OUT_EN
    ,
    output logic [WIDTH/GROUP-1:0] grp_p,
    output logic [WIDTH/GROUP-1:0] grp_g
`endif
);
    localparam int NGROUP = cla_ngroup(WIDTH, GROUP);
    localparam int STAGES = CLA_STAGES;

    if (!cla_cfg_ok(WIDTH, GROUP)) begin : g_cfg_chk
        $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP");
    end

    logic [STAGES:1] vld_pipe;
    logic            en;

    // A single enable freezes every stage, so backpressure never drops beats.
    assign en        = !vld_pipe[STAGES] | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // ---- S1: bit p/g and group P/G ----
    logic [WIDTH-1:0]  p0, g0, s1_c_unused;
    logic [NGROUP-1:0] gp0, gg0;
    logic [WIDTH-1:0]  p1, g1;
    logic [NGROUP-1:0] gp1, gg1;
    logic              cin1;

    assign p0 = a ^ b;
    assign g0 = a & b;

    for (genvar k = 0; k < NGROUP; k++) begin : g_s1
        cla_group #(.GROUP(GROUP)) u_grp (
            .p    (p0[k*GROUP +: GROUP]),
            .g    (g0[k*GROUP +: GROUP]),
            .c_in (1'b0),
            .gp   (gp0[k]),
            .gg   (gg0[k]),
            .c    (s1_c_unused[k*GROUP +: GROUP])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0; g1 <= '0; gp1 <= '0; gg1 <= '0; cin1 <= 1'b0;
        end else if (en) begin
            p1 <= p0; g1 <= g0; gp1 <= gp0; gg1 <= gg0; cin1 <= cin;
        end
    end

    // ---- S2: group carries, each a flat sum of products (no group ripple) ----
    logic [NGROUP:0]   c_grp_n, c2;
    logic [WIDTH-1:0]  p2, g2;
    logic [NGROUP:0]   gen_ext;

    assign gen_ext = {gg1, cin1};

    always_comb begin
        logic t, cc;
        t       = 1'b0;
        cc      = 1'b0;
        c_grp_n = '0;
        c_grp_n[0] = cin1;
        for (int k = 0; k < NGROUP; k++) begin
            cc = 1'b0;
            // gen_ext[j] is cin (j=0) or GG[j-1], propagated through GP[j..k].
            for (int j = 0; j <= k + 1; j++) begin
                t = gen_ext[j];
                for (int m = j; m <= k; m++) t = t & gp1[m];
                cc = cc | t;
            end
            c_grp_n[k+1] = cc;
        end
    end

`ifdef CLA_PIPE_PG_OUT_EN
    logic [NGROUP-1:0] gp2, gg2, gp3, gg3;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2 <= '0; g2 <= '0; c2 <= '0;
`ifdef CLA_PIPE_PG_OUT_EN
            gp2 <= '0; gg2 <= '0;
`endif
        end else if (en) begin
            p2 <= p1; g2 <= g1; c2 <= c_grp_n;
`ifdef CLA_PIPE_PG_OUT_EN
            gp2 <= gp1; gg2 <= gg1;
`endif
        end
    end

    // ---- S3: in-group carries, sum, cout, overflow ----
    logic [WIDTH-1:0]  c3;
    logic [NGROUP-1:0] s3_gp_unused, s3_gg_unused;
    logic [WIDTH-1:0]  sum_n;
    logic              ovf_n;

    for (genvar k = 0; k < NGROUP; k++) begin : g_s3
        cla_group #(.GROUP(GROUP)) u_grp (
            .p    (p2[k*GROUP +: GROUP]),
            .g    (g2[k*GROUP +: GROUP]),
            .c_in (c2[k]),
            .gp   (s3_gp_unused[k]),
            .gg   (s3_gg_unused[k]),
            .c    (c3[k*GROUP +: GROUP])
        );
    end

    assign sum_n = p2 ^ c3;
    assign ovf_n = c3[WIDTH-1] ^ c2[NGROUP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0; cout <= 1'b0; ovf <= 1'b0;
`ifdef CLA_PIPE_PG_OUT_EN
            gp3 <= '0; gg3 <= '0;
`endif
        end else if (en) begin
            sum <= sum_n; cout <= c2[NGROUP]; ovf <= ovf_n;
`ifdef CLA_PIPE_PG_OUT_EN
            gp3 <= gp2; gg3 <= gg2;
`endif
        end
    end

`ifdef CLA_PIPE_PG_OUT_EN
    assign grp_p = gp3;
    assign grp_g = gg3;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed corners, backpressure, mid-flight reset, random traffic.
module tb_cla_pipe_adder;
    localparam int W  = 28;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;
`ifdef CLA_PIPE_PG_OUT_EN
    logic [NG-1:0] grp_p, grp_g;
`endif

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
`ifdef CLA_PIPE_PG_OUT_EN
        , .grp_p(grp_p), .grp_g(grp_g)
`endif
    );

    typedef struct {
        logic [W-1:0]  s;
        logic          co, ov;
        logic [NG-1:0] gp, gg;
        int            cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0, n_fail = 0, cyc = 0, n_out = 0;
    bit         chk_lat;
    logic [3:1] mv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici);
        exp_t       e;
        logic [W:0] t;
        logic [G:0] gs;
        logic [G-1:0] as, bs;
        t    = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ici};
        e.s  = t[W-1:0];
        e.co = t[W];
        e.ov = (ia[W-1] == ib[W-1]) && (t[W-1] != ia[W-1]);
        e.gp = '0;
        e.gg = '0;
        for (int k = 0; k < NG; k++) begin
            as      = ia[k*G +: G];
            bs      = ib[k*G +: G];
            gs      = {1'b0, as} + {1'b0, bs};
            e.gp[k] = &(as ^ bs);
            e.gg[k] = gs[G];
        end
        e.cyc = 0;
        return e;
    endfunction

    // One clock: drive at negedge, check just after, update handshake model for the next edge.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ici, input logic ordy, output bit acc);
        exp_t e;
        logic en_m;
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; cin = ici; out_ready = ordy;
        #1;
        en_m = !mv[3] | ordy;
        chk("in_ready", 64'(in_ready), 64'(en_m));
        chk("out_valid", 64'(out_valid), 64'(mv[3]));
        if (out_valid) begin
            if (sb.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
            else if (ordy) begin
                e = sb.pop_front();
                n_out++;
                chk("sum", 64'(sum), 64'(e.s));
                chk("cout", 64'(cout), 64'(e.co));
                chk("ovf", 64'(ovf), 64'(e.ov));
`ifdef CLA_PIPE_PG_OUT_EN
                chk("grp_p", 64'(grp_p), 64'(e.gp));
                chk("grp_g", 64'(grp_g), 64'(e.gg));
`endif
                if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(3));
            end else begin
                chk("hold_sum", 64'(sum), 64'(sb[0].s));
                chk("hold_cout", 64'(cout), 64'(sb[0].co));
            end
        end
        acc = rst_n && iv && en_m;
        if (acc) begin
            e = model(ia, ib, ici);
            e.cyc = cyc;
            sb.push_back(e);
        end
        if (!rst_n) mv = '0;
        else if (en_m) mv = {mv[2:1], iv};
        cyc++;
    endtask

    logic [W-1:0] va[10], vb[10];
    logic         vc[10];
    logic [W-1:0] da[4], db[4];
    logic         dc[4];

    initial begin
        bit acc, stalled;
        int idx, stall, n_out0, n_ir_low, sent, guard;
        logic [31:0] r;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0; mv = '0;
        chk_lat = 1'b1;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed corners, one beat at a time with latency checks.
        da[0] = 28'h0000005; db[0] = 28'h0000003; dc[0] = 1'b0;
        da[1] = 28'hFFFFFFF; db[1] = 28'h0000001; dc[1] = 1'b0;
        da[2] = 28'h7FFFFFF; db[2] = 28'h0000001; dc[2] = 1'b0;
        da[3] = 28'hFFFFFFF; db[3] = 28'h0000000; dc[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, da[i], db[i], dc[i], 1'b1, acc);
            chk("dir_accept", 64'(acc), 64'(1));
            repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        chk("dir_drained", 64'(sb.size()), 64'(0));
        chk("dir_count", 64'(n_out), 64'(4));

        // Ten back-to-back beats, five stall cycles after the third result.
        chk_lat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            r = $urandom(); va[i] = r[W-1:0];
            r = $urandom(); vb[i] = r[W-1:0];
            vc[i] = r[31];
        end
        idx = 0; stall = 0; stalled = 1'b0; n_out0 = n_out; n_ir_low = 0; guard = 0;
        while ((idx < 10 || sb.size() > 0) && guard < 80) begin
            step(idx < 10, va[idx % 10], vb[idx % 10], vc[idx % 10], stall == 0, acc);
            if (stall > 0 && !in_ready) n_ir_low++;
            if (acc) idx++;
            if (stall > 0) stall--;
            else if (!stalled && n_out - n_out0 == 3) begin stall = 5; stalled = 1'b1; end
            guard++;
        end
        chk("bp_results", 64'(n_out - n_out0), 64'(10));
        chk("bp_in_ready_low", 64'(n_ir_low), 64'(5));

        // Reset with three beats in flight.
        repeat (3) step(1'b1, 28'h1234567, 28'h0ABCDEF, 1'b1, 1'b1, acc);
        @(posedge clk); #2;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        mv = '0;
        sb.delete();
        repeat (2) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk_lat = 1'b1;
        n_out0 = n_out;
        step(1'b1, 28'h0FF00FF, 28'h0F0F0F0, 1'b0, 1'b1, acc);
        repeat (5) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("post_rst_count", 64'(n_out - n_out0), 64'(1));

        // Random traffic with random valid/ready.
        chk_lat = 1'b0;
        sent = 0; guard = 0;
        while (sent < 10000 && guard < 60000) begin
            r = $urandom(); ra = r[W-1:0];
            r = $urandom(); rb = r[W-1:0];
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = '0;
                2: ra = {1'b0, {(W-1){1'b1}}};
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, ra, rb, r[31], $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
            guard++;
        end
        chk("rand_sent", 64'(sent), 64'(10000));
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
